// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S receive path: FIFO entry width,
// slot/sample defaults, word-select encoding and sample sign extension.
package i2s_pkg;

  localparam int ENTRY_W      = 32;
  localparam int SLOT_W_DEF   = 32;
  localparam int SAMPLE_W_DEF = 24;
  localparam int IDX_W        = $clog2(ENTRY_W);

  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

  // Replicates bit (width-1) of a zero-extended sample into all higher bits.
  function automatic logic [ENTRY_W-1:0] sign_extend(input logic [ENTRY_W-1:0] raw,
                                                     input int width);
    logic [ENTRY_W-1:0] low_mask;
    logic [IDX_W-1:0]   msb_idx;
    low_mask = (ENTRY_W'(1) << width) - ENTRY_W'(1);
    msb_idx  = IDX_W'(width - 1);
    return raw[msb_idx] ? (raw | ~low_mask) : (raw & low_mask);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-bit pointers, shared
// with the DMAC. A push while full with no pop is dropped and flagged on drop_o.
module sync_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   drop_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible behind the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/i2s_rx_fifo.sv
// I2S master receiver: BCLK/WS generation, DIN deserialiser and sample FIFO with DMA request.
// Define I2S_STEREO_EN to capture both slots ({ws, 31-bit sample}); default keeps the left slot only.
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SLOT_W     = SLOT_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int DMA_THRESH = 4
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        en,
  input  logic                        i2s_din,
  output logic                        i2s_bclk,
  output logic                        i2s_ws,
  input  logic                        rd_en,
  output logic [ENTRY_W-1:0]          rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic                        dma_req,
  output logic                        overrun,
  input  logic                        clr_overrun
);

`ifdef I2S_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                push_q, push_d;
  ws_e                 push_ws_q, push_ws_d;
  logic                overrun_q, overrun_d;

  logic                div_wrap, rise_stb, fall_stb;
  ws_e                 ws;
  logic [BIT_W-1:0]    slot_k;
  logic                capture;
  logic [ENTRY_W-1:0]  sample_ext, fifo_wdata;
  logic                fifo_drop;

  assign div_wrap = en && (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_stb = div_wrap && !bclk_q;
  assign fall_stb = div_wrap && bclk_q;

  assign ws     = (bit_cnt_q >= BIT_W'(SLOT_W)) ? WS_RIGHT : WS_LEFT;
  assign slot_k = (ws == WS_RIGHT) ? (bit_cnt_q - BIT_W'(SLOT_W)) : bit_cnt_q;

  // One-bit I2S delay: slot bit 0 carries the previous word's LSB, data occupies bits 1..SAMPLE_W.
  assign capture = rise_stb && (slot_k >= BIT_W'(1)) && (slot_k <= BIT_W'(SAMPLE_W))
                   && (STEREO || (ws == WS_LEFT));

  always_comb begin
    div_d     = div_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    push_ws_d = push_ws_q;
    if (!en) begin
      div_d     = '0;
      bclk_d    = 1'b0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) bclk_d = ~bclk_q;
      if (fall_stb) begin
        bit_cnt_d = (bit_cnt_q == BIT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
      end
      if (capture) begin
        shift_d = {shift_q[SAMPLE_W-2:0], i2s_din};
        if (slot_k == BIT_W'(SAMPLE_W)) begin
          push_d    = 1'b1;
          push_ws_d = ws;
        end
      end
    end
  end

  // Set wins over clear so a drop coinciding with a software clear is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop)        overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      push_ws_q <= WS_LEFT;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      push_ws_q <= push_ws_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_ext = sign_extend(ENTRY_W'(shift_q), SAMPLE_W);
  assign fifo_wdata = STEREO ? {push_ws_q, sample_ext[ENTRY_W-2:0]} : sample_ext;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push_q),
    .wdata_i (fifo_wdata),
    .pop_i   (rd_en),
    .rdata_o (rd_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // Outputs are gated by en so that disabling silences the bus in the same cycle.
  assign i2s_bclk = en && bclk_q;
  assign i2s_ws   = en && (ws == WS_RIGHT);
  assign dma_req  = (fifo_level >= LVL_W'(DMA_THRESH));
  assign overrun  = overrun_q;

endmodule
